des_round_ctrl: RTL and testbench

Iterative DES round sequencer. It drives one shared Feistel F-function datapath (expansion, key mix, sbox_layer, P-permutation) through 16 rounds per block, one round per clock. It owns the L/R state, the C/D key-schedule rotation and the round counter, and exposes valid/ready handshakes on input and output. It sits between the IP/PC-1 front end and the IP⁻¹ back end; the F datapath is purely combinational and lives outside this block.

---
 rtl/des_pkg.sv | 49 ++++
 rtl/des_key_rot.sv | 30 +++
 rtl/des_round_ctrl.sv | 135 +++++++++++++
 tb/tb_des_round_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// des_pkg: shared types and helpers for the iterative DES round controller.
//   des_state_e   : controller FSM states
//   DES_ROUNDS    : rounds per block (16)
//   DES_SHIFT     : per-round key-schedule left-shift count, indexed by round
//   rotl28/rotr28 : 28-bit rotate by 0..2 positions
package des_pkg;

  localparam int unsigned DES_ROUNDS = 16;
  localparam int unsigned HALF_W     = 32;
  localparam int unsigned BLK_W      = 64;
  localparam int unsigned KEY_HALF_W = 28;
  localparam int unsigned KEY_W      = 56;
  localparam int unsigned RND_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } des_state_e;

  // Element 0 is round 0; listed from round 15 down to round 0.
  localparam logic [DES_ROUNDS-1:0][1:0] DES_SHIFT = {
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1,
    2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1
  };

  function automatic logic [KEY_HALF_W-1:0] rotl28(input logic [KEY_HALF_W-1:0] x,
                                                   input logic [1:0] n);
    logic [KEY_HALF_W-1:0] y;
    case (n)
      2'd1:    y = {x[KEY_HALF_W-2:0], x[KEY_HALF_W-1]};
      2'd2:    y = {x[KEY_HALF_W-3:0], x[KEY_HALF_W-1:KEY_HALF_W-2]};
      default: y = x;
    endcase
    return y;
  endfunction

  function automatic logic [KEY_HALF_W-1:0] rotr28(input logic [KEY_HALF_W-1:0] x,
                                                   input logic [1:0] n);
    logic [KEY_HALF_W-1:0] y;
    case (n)
      2'd1:    y = {x[0], x[KEY_HALF_W-1:1]};
      2'd2:    y = {x[1:0], x[KEY_HALF_W-1:2]};
      default: y = x;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/des_key_rot.sv
// des_key_rot: combinational C/D key-schedule rotation for the current round.
//   cd_i      : {C,D} before this round's rotation
//   rnd_i     : round number 0..15
//   decrypt_i : 1 = rotate right (reverse subkey order)
//   cd_rot_o  : rotated {C,D}, C and D rotated independently
module des_key_rot
  import des_pkg::*;
(
  input  logic [KEY_W-1:0] cd_i,
  input  logic [RND_W-1:0] rnd_i,
  input  logic             decrypt_i,
  output logic [KEY_W-1:0] cd_rot_o
);

  logic [1:0] amt;

  // Decrypt round 0 uses the unrotated key: after 16 encrypt rounds C/D are back at C0/D0.
  always_comb begin
    amt = DES_SHIFT[rnd_i];
    if (decrypt_i && (rnd_i == '0)) begin
      amt = 2'd0;
    end
    if (decrypt_i) begin
      cd_rot_o = {rotr28(cd_i[KEY_W-1:KEY_HALF_W], amt), rotr28(cd_i[KEY_HALF_W-1:0], amt)};
    end else begin
      cd_rot_o = {rotl28(cd_i[KEY_W-1:KEY_HALF_W], amt), rotl28(cd_i[KEY_HALF_W-1:0], amt)};
    end
  end

endmodule

// File: rtl/des_round_ctrl.sv
// des_round_ctrl: iterative DES round sequencer, one Feistel round per clock.
// Owns L/R, the C/D key rotation and the round counter; the F datapath is
// external and combinational (f_r/f_cd out, f_res back).
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : input handshake; in_block={L0,R0}, in_key={C0,D0}, in_decrypt
//   f_r, f_cd, f_res    : F-datapath operands and result
//   out_valid/out_ready : output handshake; out_block={R16,L16}
//   busy                : high while rounds are in progress
// Optional: define DES_ROUND_CTRL_ABORT_EN to add input 'abort', which returns
// the block to IDLE from ROUND or DONE and clears L/R/CD.
module des_round_ctrl
  import des_pkg::*;
#(
  parameter int unsigned ROUNDS = DES_ROUNDS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_block,
  input  logic [55:0] in_key,
  input  logic        in_decrypt,
  output logic [31:0] f_r,
  output logic [55:0] f_cd,
  input  logic [31:0] f_res,
  output logic        out_valid,
  input  logic        out_ready,
`ifdef DES_ROUND_CTRL_ABORT_EN
  input  logic        abort,
`endif
  output logic [63:0] out_block,
  output logic        busy
);

  localparam logic [RND_W-1:0] LAST_RND = RND_W'(ROUNDS - 1);

  des_state_e         state_q;
  logic [HALF_W-1:0]  l_q, r_q;
  logic [KEY_W-1:0]   cd_q;
  logic [RND_W-1:0]   rnd_q;
  logic               dec_q;
  logic               in_ready_q, out_valid_q, busy_q;
  logic [BLK_W-1:0]   out_block_q;
  logic [KEY_W-1:0]   cd_rot;
  logic [HALF_W-1:0]  r_new;

  des_key_rot u_key_rot (
    .cd_i      (cd_q),
    .rnd_i     (rnd_q),
    .decrypt_i (dec_q),
    .cd_rot_o  (cd_rot)
  );

  assign r_new = l_q ^ f_res;

  // Controller FSM with registered handshake/status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      l_q         <= '0;
      r_q         <= '0;
      cd_q        <= '0;
      rnd_q       <= '0;
      dec_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      out_block_q <= '0;
    end else begin
`ifdef DES_ROUND_CTRL_ABORT_EN
      if (abort && (state_q != ST_IDLE)) begin
        state_q     <= ST_IDLE;
        l_q         <= '0;
        r_q         <= '0;
        cd_q        <= '0;
        rnd_q       <= '0;
        in_ready_q  <= 1'b1;
        out_valid_q <= 1'b0;
        busy_q      <= 1'b0;
      end else begin
`endif
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            l_q        <= in_block[BLK_W-1:HALF_W];
            r_q        <= in_block[HALF_W-1:0];
            cd_q       <= in_key;
            dec_q      <= in_decrypt;
            rnd_q      <= '0;
            state_q    <= ST_ROUND;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        ST_ROUND: begin
          l_q   <= r_q;
          r_q   <= r_new;
          cd_q  <= cd_rot;
          rnd_q <= rnd_q + RND_W'(1);
          if (rnd_q == LAST_RND) begin
            state_q     <= ST_DONE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
            // Preoutput swap: {R16, L16}
            out_block_q <= {r_new, r_q};
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
`ifdef DES_ROUND_CTRL_ABORT_EN
      end
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_block = out_block_q;
  assign f_r       = r_q;
  assign f_cd      = cd_rot;

endmodule

// File: tb/tb_des_round_ctrl.sv
// Bench for des_round_ctrl: provides the DES F function behind f_r/f_cd/f_res,
// a whole-block reference model, vector table, corner sequences and random blocks.
module tb_des_round_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_block = '0;
  logic [55:0] in_key = '0;
  logic        in_decrypt = 1'b0;
  logic [31:0] f_r;
  logic [55:0] f_cd;
  logic [31:0] f_res;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_block;
  logic        busy;
`ifdef DES_ROUND_CTRL_ABORT_EN
  logic        abort = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  des_round_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_block   (in_block),
    .in_key     (in_key),
    .in_decrypt (in_decrypt),
    .f_r        (f_r),
    .f_cd       (f_cd),
    .f_res      (f_res),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
`ifdef DES_ROUND_CTRL_ABORT_EN
    .abort      (abort),
`endif
    .out_block  (out_block),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // ---------------- DES tables ----------------
  localparam int ENC_SH [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  localparam int P_TBL [32] = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
                                2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
  localparam int PC2_TBL [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,
                                  16,7,27,20,13,2,41,52,31,37,47,55,30,40,51,45,33,48,
                                  44,49,39,56,34,53,46,42,50,36,29,32};
  localparam int SBOX [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
  };

  // ---------------- F function (DES bit 1 = MSB) ----------------
  function automatic logic [47:0] e_exp(input logic [31:0] r);
    logic [47:0] e;
    for (int i = 0; i < 48; i++) e[47-i] = r[32 - (((4*(i/6) + (i%6) + 31) % 32) + 1)];
    return e;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] k;
    for (int i = 0; i < 48; i++) k[47-i] = cd[56 - PC2_TBL[i]];
    return k;
  endfunction

  function automatic logic [31:0] sbox_layer(input logic [47:0] x);
    logic [31:0] o;
    logic [5:0]  six;
    int row, col;
    o = '0;
    for (int s = 0; s < 8; s++) begin
      six = x[47-6*s -: 6];
      row = int'({six[5], six[0]});
      col = int'(six[4:1]);
      o[31-4*s -: 4] = 4'(SBOX[s][row*16 + col]);
    end
    return o;
  endfunction

  function automatic logic [31:0] perm_p(input logic [31:0] x);
    logic [31:0] p;
    for (int i = 0; i < 32; i++) p[31-i] = x[32 - P_TBL[i]];
    return p;
  endfunction

  function automatic logic [31:0] des_f(input logic [31:0] r, input logic [55:0] cd);
    return perm_p(sbox_layer(e_exp(r) ^ pc2(cd)));
  endfunction

  always_comb f_res = des_f(f_r, f_cd);

  // ---------------- reference model ----------------
  function automatic logic [27:0] rotl(input logic [27:0] x, input int n);
    logic [55:0] t;
    t = {x, x};
    return t[55-n -: 28];
  endfunction

  // {C,D} feeding PC-2 in round rnd (0-based): subkey K(rnd+1) encrypt, K(16-rnd) decrypt.
  function automatic logic [55:0] model_cd(input logic [55:0] key, input logic dec, input int rnd);
    int idx, cum;
    idx = dec ? (16 - rnd) : (rnd + 1);
    cum = 0;
    for (int j = 0; j < idx; j++) cum += ENC_SH[j];
    cum = cum % 28;
    return {rotl(key[55:28], cum), rotl(key[27:0], cum)};
  endfunction

  function automatic logic [63:0] model_des(input logic [63:0] blk, input logic [55:0] key,
                                            input logic dec);
    logic [31:0] l, r, t;
    l = blk[63:32];
    r = blk[31:0];
    for (int i = 0; i < 16; i++) begin
      t = l ^ des_f(r, model_cd(key, dec, i));
      l = r;
      r = t;
    end
    return {r, l};
  endfunction

  // ---------------- helpers ----------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_idle(input string nm);
    int w;
    w = 0;
    while (!in_ready && w < 60) begin
      step();
      w++;
    end
    chk({nm, "_idle_wait"}, 64'(in_ready), 64'd1);
  endtask

  // One block end to end: latency, busy length, result, optional f_cd trace and stall.
  task automatic run_vec(input string nm, input logic [63:0] blk, input logic [55:0] key,
                         input logic dec, input logic [63:0] exp_blk, input bit chk_cd,
                         input bit chk_r1, input int stall);
    int lat, busy_n;
    wait_idle(nm);
    in_block = blk; in_key = key; in_decrypt = dec; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    in_block = ~blk;
    lat = 0; busy_n = 0;
    while (!out_valid && lat < 40) begin
      if (busy) busy_n++;
      if (chk_cd && lat < 16) chk($sformatf("%s_fcd_r%0d", nm, lat), 64'(f_cd), 64'(model_cd(key, dec, lat)));
      if (chk_r1 && lat == 0) begin
        chk({nm, "_r1_sbox_in"}, 64'(e_exp(f_r) ^ pc2(f_cd)), 64'h6117BA866527);
        chk({nm, "_r1_sbox_out"}, 64'(sbox_layer(e_exp(f_r) ^ pc2(f_cd))), 64'h5C82B597);
      end
      step();
      lat++;
    end
    chk({nm, "_latency"}, 64'(lat), 64'd16);
    chk({nm, "_busy_cycles"}, 64'(busy_n), 64'd16);
    chk({nm, "_out_block"}, out_block, exp_blk);
    if (stall > 0) begin
      for (int s = 0; s < stall; s++) begin
        in_valid = 1'b1;
        step();
        chk({nm, "_stall_hold"}, out_block, exp_blk);
        chk({nm, "_stall_valid"}, 64'(out_valid), 64'd1);
        chk({nm, "_stall_in_ready"}, 64'(in_ready), 64'd0);
      end
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({nm, "_post_valid"}, 64'(out_valid), 64'd0);
    chk({nm, "_post_busy"}, 64'(busy), 64'd0);
    chk({nm, "_post_in_ready"}, 64'(in_ready), 64'd1);
  endtask

  typedef struct {
    logic [63:0] blk;
    logic [55:0] key;
    logic        dec;
    logic [63:0] exp;
    bit          chk_cd;
    bit          chk_r1;
  } vec_t;

  localparam logic [55:0] KNOWN_KEY = 56'hF0CCAAF556678F;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected normal finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    logic [63:0] rb;
    logic [55:0] rk;
    logic        rd;
    int          t_out[3];
    int          got, idx, cyc, seen;

    vecs[0] = '{64'hCC00CCFF_F0AAF0AA, KNOWN_KEY, 1'b0, 64'h0A4CD995_43423234, 1'b1, 1'b1};
    vecs[1] = '{64'h0A4CD995_43423234, KNOWN_KEY, 1'b1, 64'hCC00CCFF_F0AAF0AA, 1'b1, 1'b0};
    for (int i = 2; i < 6; i++) begin
      rb = {32'($urandom), 32'($urandom)};
      rk = 56'({32'($urandom), 32'($urandom)});
      rd = 1'(i % 2);
      vecs[i] = '{rb, rk, rd, model_des(rb, rk, rd), 1'b0, 1'b0};
    end

    // Reset values, while held in reset and after release
    repeat (3) step();
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_out_block", out_block, 64'd0);
    chk("rst_f_r", 64'(f_r), 64'd0);
    chk("rst_f_cd", 64'(f_cd), 64'd0);
    rst = 1'b0;
    step();
    chk("rel_in_ready", 64'(in_ready), 64'd1);

    // Vector table
    for (int i = 0; i < 6; i++)
      run_vec($sformatf("vec%0d", i), vecs[i].blk, vecs[i].key, vecs[i].dec, vecs[i].exp,
              vecs[i].chk_cd, vecs[i].chk_r1, 0);

    // Backpressure: 5 stalled cycles in DONE with a competing in_valid
    run_vec("stall", vecs[0].blk, vecs[0].key, 1'b0, vecs[0].exp, 1'b0, 1'b0, 5);

    // Reset at rnd=7, then a fresh block
    wait_idle("rstmid");
    in_block = vecs[2].blk; in_key = vecs[2].key; in_decrypt = vecs[2].dec; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (7) step();
    chk("rstmid_busy_before", 64'(busy), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstmid_in_ready", 64'(in_ready), 64'd1);
    chk("rstmid_busy", 64'(busy), 64'd0);
    chk("rstmid_out_valid", 64'(out_valid), 64'd0);
    seen = 0;
    repeat (20) begin
      step();
      if (out_valid) seen++;
    end
    chk("rstmid_no_output", 64'(seen), 64'd0);
    run_vec("rstmid_fresh", vecs[3].blk, vecs[3].key, vecs[3].dec, vecs[3].exp, 1'b0, 1'b0, 0);

    // Back-to-back: in_valid and out_ready held high for three blocks
    wait_idle("b2b");
    out_ready = 1'b1;
    got = 0; idx = 0; cyc = 0;
    while (got < 3 && cyc < 200) begin
      if (out_valid) begin
        chk($sformatf("b2b_out%0d", got), out_block, vecs[2+got].exp);
        t_out[got] = cyc;
        got++;
      end
      if (in_ready) begin
        if (idx < 3) begin
          in_block = vecs[2+idx].blk; in_key = vecs[2+idx].key; in_decrypt = vecs[2+idx].dec;
          in_valid = 1'b1;
          idx++;
        end else begin
          in_valid = 1'b0;
        end
      end
      step();
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("b2b_count", 64'(got), 64'd3);
    if (got == 3) begin
      chk("b2b_gap01", 64'(t_out[1] - t_out[0]), 64'd18);
      chk("b2b_gap12", 64'(t_out[2] - t_out[1]), 64'd18);
    end
    step();

`ifdef DES_ROUND_CTRL_ABORT_EN
    // Abort at rnd=3
    wait_idle("abort");
    in_block = vecs[4].blk; in_key = vecs[4].key; in_decrypt = vecs[4].dec; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (3) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_f_r", 64'(f_r), 64'd0);
    seen = 0;
    repeat (20) begin
      step();
      if (out_valid) seen++;
    end
    chk("abort_no_output", 64'(seen), 64'd0);
    run_vec("abort_fresh", vecs[5].blk, vecs[5].key, vecs[5].dec, vecs[5].exp, 1'b0, 1'b0, 0);
`endif

    // Random blocks, keys, directions and stalls
    for (int i = 0; i < 12; i++) begin
      rb = {32'($urandom), 32'($urandom)};
      rk = 56'({32'($urandom), 32'($urandom)});
      rd = 1'($urandom_range(0, 1));
      run_vec($sformatf("rand%0d", i), rb, rk, rd, model_des(rb, rk, rd), (i < 2), 1'b0,
              int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
